// File: rtl/cv32e40p_instr_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_instr_bus_arbiter
// Brief    : Two-requester OBI arbiter sharing the single instruction-memory
//            port between the IF-stage prefetcher (requester 0) and a
//            secondary instruction-side master (requester 1). One address
//            phase is granted per cycle. Up to MAX_OUTSTANDING transactions
//            may be in flight. Responses are routed back in order using a
//            1-bit requester-id tag FIFO.
// Ports    : clk, rst_n (async, active-low)
//            m0_* / m1_* : requester-side OBI (req/addr in, gnt/rvalid/rdata/err out)
//            s_*         : memory-side OBI (req/addr out, gnt/rvalid/rdata/err in)
//            busy_o         : one or more transactions outstanding
//            protocol_err_o : response seen with nothing outstanding
// Revision : 1.0 - initial release
// ============================================================================
module cv32e40p_instr_bus_arbiter #(
    parameter int MAX_OUTSTANDING = 2,     // legal 1..8
    parameter bit FIXED_PRIO      = 1'b0   // 0: round-robin, 1: requester 0 wins ties
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m0_req_i,
    input  logic [31:0] m0_addr_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_err_o,

    input  logic        m1_req_i,
    input  logic [31:0] m1_addr_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_err_o,

    output logic        s_req_o,
    output logic [31:0] s_addr_o,
    input  logic        s_gnt_i,
    input  logic        s_rvalid_i,
    input  logic [31:0] s_rdata_i,
    input  logic        s_err_i,

    output logic        busy_o,
    output logic        protocol_err_o
);

    localparam int c_CNT_W      = $clog2(MAX_OUTSTANDING + 1);
    localparam int c_PTR_W      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    // Storage is rounded up to a power of two so any pointer value indexes a
    // real bit; only the first MAX_OUTSTANDING entries are ever used.
    localparam int c_FIFO_DEPTH = 1 << c_PTR_W;

    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(MAX_OUTSTANDING);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(MAX_OUTSTANDING - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0]      r_cnt;
    logic [c_PTR_W-1:0]      r_wr_ptr;
    logic [c_PTR_W-1:0]      r_rd_ptr;
    logic [c_FIFO_DEPTH-1:0] r_tags;
    logic                    r_last;

    // ------------------------------------------------------------------
    // Combinational arbitration and routing
    // ------------------------------------------------------------------
    logic w_tie_winner;
    logic w_winner;
    logic w_full;
    logic w_empty;
    logic w_hs;
    logic w_pop;
    logic w_head;

    if (FIXED_PRIO) begin : g_fixed_prio
        assign w_tie_winner = 1'b0;
    end else begin : g_round_robin
        // Favour whoever did not win the previous handshake.
        assign w_tie_winner = ~r_last;
    end

    // m1 wins only if it requests and either m0 is idle or the tie goes to m1.
    // With no requester active the winner is 0, so s_addr_o follows m0_addr_i.
    assign w_winner = m1_req_i & (~m0_req_i | w_tie_winner);

    assign w_full  = (r_cnt == c_CNT_MAX);
    assign w_empty = (r_cnt == '0);

    // full deliberately ignores a same-cycle response: keeps s_rvalid_i out
    // of the s_req_o cone.
    assign s_req_o  = (m0_req_i | m1_req_i) & ~w_full;
    assign s_addr_o = w_winner ? m1_addr_i : m0_addr_i;

    assign w_hs     = s_req_o & s_gnt_i;
    assign m0_gnt_o = w_hs & ~w_winner;
    assign m1_gnt_o = w_hs &  w_winner;

    assign w_head = r_tags[r_rd_ptr];
    assign w_pop  = s_rvalid_i & ~w_empty;

    assign m0_rvalid_o = w_pop & ~w_head;
    assign m1_rvalid_o = w_pop &  w_head;
    assign m0_rdata_o  = s_rdata_i;
    assign m1_rdata_o  = s_rdata_i;
    assign m0_err_o    = s_err_i;
    assign m1_err_o    = s_err_i;

    // A response with nothing outstanding is dropped and flagged; it leaves
    // the state untouched because w_pop is already qualified by ~w_empty.
    assign protocol_err_o = s_rvalid_i & w_empty;
    assign busy_o         = ~w_empty;

    // ------------------------------------------------------------------
    // Pointer advance, wrapping modulo MAX_OUTSTANDING
    // ------------------------------------------------------------------
    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + c_PTR_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_tags   <= '0;
            r_last   <= 1'b1;   // requester 0 wins the first tie
        end else begin
            if (w_hs) begin
                r_tags[r_wr_ptr] <= w_winner;
                r_wr_ptr         <= ptr_inc(r_wr_ptr);
                r_last           <= w_winner;
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            // Simultaneous push and pop leave the count unchanged.
            case ({w_hs, w_pop})
                2'b10:   r_cnt <= r_cnt + c_CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - c_CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_instr_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cv32e40p_instr_bus_arbiter
// Brief    : Directed self-checking bench for cv32e40p_instr_bus_arbiter.
//            A round-robin instance and a fixed-priority instance share all
//            inputs; outputs are checked half a cycle after inputs change.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_instr_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        m0_req_i, m1_req_i;
    logic [31:0] m0_addr_i, m1_addr_i;
    logic        s_gnt_i, s_rvalid_i, s_err_i;
    logic [31:0] s_rdata_i;

    logic        m0_gnt_o, m0_rvalid_o, m0_err_o;
    logic [31:0] m0_rdata_o;
    logic        m1_gnt_o, m1_rvalid_o, m1_err_o;
    logic [31:0] m1_rdata_o;
    logic        s_req_o, busy_o, protocol_err_o;
    logic [31:0] s_addr_o;

    logic        fp_m0_gnt, fp_m0_rvalid, fp_m0_err;
    logic [31:0] fp_m0_rdata;
    logic        fp_m1_gnt, fp_m1_rvalid, fp_m1_err;
    logic [31:0] fp_m1_rdata;
    logic        fp_s_req, fp_busy, fp_perr;
    logic [31:0] fp_s_addr;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    cv32e40p_instr_bus_arbiter #(.MAX_OUTSTANDING(2), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_gnt_o(m0_gnt_o),
        .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
        .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_gnt_o(m1_gnt_o),
        .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
        .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_gnt_i(s_gnt_i),
        .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i), .s_err_i(s_err_i),
        .busy_o(busy_o), .protocol_err_o(protocol_err_o)
    );

    cv32e40p_instr_bus_arbiter #(.MAX_OUTSTANDING(2), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_gnt_o(fp_m0_gnt),
        .m0_rvalid_o(fp_m0_rvalid), .m0_rdata_o(fp_m0_rdata), .m0_err_o(fp_m0_err),
        .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_gnt_o(fp_m1_gnt),
        .m1_rvalid_o(fp_m1_rvalid), .m1_rdata_o(fp_m1_rdata), .m1_err_o(fp_m1_err),
        .s_req_o(fp_s_req), .s_addr_o(fp_s_addr), .s_gnt_i(s_gnt_i),
        .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i), .s_err_i(s_err_i),
        .busy_o(fp_busy), .protocol_err_o(fp_perr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        m0_req_i   = 1'b0;  m0_addr_i = 32'h0;
        m1_req_i   = 1'b0;  m1_addr_i = 32'h0;
        s_gnt_i    = 1'b0;  s_rvalid_i = 1'b0;
        s_rdata_i  = 32'h0; s_err_i    = 1'b0;
    endtask

    // Inputs are driven 1 ns after a rising edge; outputs are sampled on the
    // following falling edge.
    task automatic settle();
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();

        // ---------------- Reset state ----------------
        settle();
        check("rst_busy",   busy_o,         1'b0);
        check("rst_perr",   protocol_err_o, 1'b0);
        check("rst_s_req",  s_req_o,        1'b0);
        check("rst_m0_gnt", m0_gnt_o,       1'b0);
        check("rst_m1_gnt", m1_gnt_o,       1'b0);
        check("rst_m0_rv",  m0_rvalid_o,    1'b0);
        check("rst_m1_rv",  m1_rvalid_o,    1'b0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // ---------------- Single requester ----------------
        m0_req_i = 1'b1; m0_addr_i = 32'h100; s_gnt_i = 1'b1;
        settle();
        check("s1_s_req",  s_req_o,  1'b1);
        check("s1_s_addr", s_addr_o, 32'h100);
        check("s1_m0_gnt", m0_gnt_o, 1'b1);
        check("s1_m1_gnt", m1_gnt_o, 1'b0);
        next_cycle();
        m0_addr_i = 32'h104; s_rvalid_i = 1'b1; s_rdata_i = 32'hA;
        settle();
        check("s2_s_addr",  s_addr_o,    32'h104);
        check("s2_m0_gnt",  m0_gnt_o,    1'b1);
        check("s2_m0_rv",   m0_rvalid_o, 1'b1);
        check("s2_m0_data", m0_rdata_o,  32'hA);
        check("s2_m1_rv",   m1_rvalid_o, 1'b0);
        check("s2_m1_gnt",  m1_gnt_o,    1'b0);
        next_cycle();
        m0_req_i = 1'b0; s_gnt_i = 1'b0; s_rdata_i = 32'hB;
        settle();
        check("s3_m0_rv",   m0_rvalid_o, 1'b1);
        check("s3_m0_data", m0_rdata_o,  32'hB);
        check("s3_m1_rv",   m1_rvalid_o, 1'b0);
        check("s3_busy",    busy_o,      1'b1);
        next_cycle();
        idle();
        settle();
        check("s4_busy", busy_o, 1'b0);
        check("s4_perr", protocol_err_o, 1'b0);
        next_cycle();

        // ---------------- Round-robin tie (last = 0 here) ----------------
        m0_req_i = 1'b1; m0_addr_i = 32'h400;
        m1_req_i = 1'b1; m1_addr_i = 32'h500;
        s_gnt_i  = 1'b1;
        settle();
        check("rr1_m1_gnt", m1_gnt_o, 1'b1);
        check("rr1_m0_gnt", m0_gnt_o, 1'b0);
        check("rr1_addr",   s_addr_o, 32'h500);
        check("fp1_m0_gnt", fp_m0_gnt, 1'b1);
        next_cycle();
        s_rvalid_i = 1'b1; s_rdata_i = 32'h11;
        settle();
        check("rr2_m0_gnt", m0_gnt_o, 1'b1);
        check("rr2_m1_gnt", m1_gnt_o, 1'b0);
        check("rr2_addr",   s_addr_o, 32'h400);
        check("rr2_m1_rv",  m1_rvalid_o, 1'b1);
        check("fp2_m0_gnt", fp_m0_gnt, 1'b1);
        next_cycle();
        s_rdata_i = 32'h22;
        settle();
        check("rr3_m1_gnt", m1_gnt_o, 1'b1);
        check("rr3_m0_rv",  m0_rvalid_o, 1'b1);
        check("fp3_m0_gnt", fp_m0_gnt, 1'b1);
        check("fp3_m1_gnt", fp_m1_gnt, 1'b0);
        next_cycle();
        s_rdata_i = 32'h33;
        settle();
        check("rr4_m0_gnt", m0_gnt_o, 1'b1);
        check("rr4_m1_rv",  m1_rvalid_o, 1'b1);
        check("fp4_m0_gnt", fp_m0_gnt, 1'b1);
        next_cycle();
        idle();
        s_rvalid_i = 1'b1; s_rdata_i = 32'h44;
        settle();
        check("rr5_m0_rv", m0_rvalid_o, 1'b1);
        check("rr5_m1_rv", m1_rvalid_o, 1'b0);
        next_cycle();

        // ---------------- Interleaved routing ----------------
        idle();
        m1_req_i = 1'b1; m1_addr_i = 32'h200; s_gnt_i = 1'b1;
        settle();
        check("il1_m1_gnt", m1_gnt_o, 1'b1);
        check("il1_addr",   s_addr_o, 32'h200);
        next_cycle();
        idle();
        m0_req_i = 1'b1; m0_addr_i = 32'h300; s_gnt_i = 1'b1;
        settle();
        check("il2_m0_gnt", m0_gnt_o, 1'b1);
        check("il2_addr",   s_addr_o, 32'h300);
        next_cycle();
        idle();
        s_rvalid_i = 1'b1; s_rdata_i = 32'hDEADBEEF;
        settle();
        check("il3_m1_rv",   m1_rvalid_o, 1'b1);
        check("il3_m1_data", m1_rdata_o,  32'hDEADBEEF);
        check("il3_m0_rv",   m0_rvalid_o, 1'b0);
        next_cycle();
        s_rdata_i = 32'h12345678;
        settle();
        check("il4_m0_rv",   m0_rvalid_o, 1'b1);
        check("il4_m0_data", m0_rdata_o,  32'h12345678);
        check("il4_m1_rv",   m1_rvalid_o, 1'b0);
        next_cycle();

        // ---------------- Full and same-cycle events ----------------
        idle();
        m0_req_i = 1'b1; m0_addr_i = 32'h600; s_gnt_i = 1'b1;
        settle();
        check("f1_m0_gnt", m0_gnt_o, 1'b1);
        next_cycle();
        m0_addr_i = 32'h604;
        settle();
        check("f2_m0_gnt", m0_gnt_o, 1'b1);
        next_cycle();
        m0_addr_i = 32'h608;                       // cnt = 2
        settle();
        check("f3_s_req",  s_req_o,  1'b0);
        check("f3_m0_gnt", m0_gnt_o, 1'b0);
        check("f3_busy",   busy_o,   1'b1);
        next_cycle();
        s_rvalid_i = 1'b1; s_rdata_i = 32'h66;     // response while full
        settle();
        check("f4_s_req",  s_req_o,     1'b0);
        check("f4_m0_gnt", m0_gnt_o,    1'b0);
        check("f4_m0_rv",  m0_rvalid_o, 1'b1);
        next_cycle();                              // cnt = 1
        settle();
        check("f5_s_req",  s_req_o,     1'b1);
        check("f5_m0_gnt", m0_gnt_o,    1'b1);
        check("f5_m0_rv",  m0_rvalid_o, 1'b1);
        next_cycle();                              // handshake + pop: cnt = 1
        idle();
        settle();
        check("f6_busy",  busy_o,  1'b1);
        next_cycle();
        m0_req_i = 1'b1; m0_addr_i = 32'h60C; s_gnt_i = 1'b1;
        settle();
        check("f7_m0_gnt", m0_gnt_o, 1'b1);
        next_cycle();                              // cnt = 2 only if it was 1
        settle();
        check("f8_s_req", s_req_o, 1'b0);
        next_cycle();
        idle();
        s_rvalid_i = 1'b1;
        next_cycle();
        next_cycle();
        idle();
        settle();
        check("f9_busy", busy_o, 1'b0);
        next_cycle();

        // ---------------- Unexpected response / error ----------------
        s_rvalid_i = 1'b1; s_rdata_i = 32'h55;
        settle();
        check("pe1_perr",  protocol_err_o, 1'b1);
        check("pe1_m0_rv", m0_rvalid_o,    1'b0);
        check("pe1_m1_rv", m1_rvalid_o,    1'b0);
        check("pe1_busy",  busy_o,         1'b0);
        next_cycle();
        idle();
        settle();
        check("pe2_perr", protocol_err_o, 1'b0);
        check("pe2_busy", busy_o,         1'b0);
        next_cycle();
        m1_req_i = 1'b1; m1_addr_i = 32'h700; s_gnt_i = 1'b1;
        settle();
        check("er1_m1_gnt", m1_gnt_o, 1'b1);
        next_cycle();
        idle();
        s_rvalid_i = 1'b1; s_err_i = 1'b1; s_rdata_i = 32'hBAD;
        settle();
        check("er2_m1_rv",  m1_rvalid_o,    1'b1);
        check("er2_m1_err", m1_err_o,       1'b1);
        check("er2_m0_rv",  m0_rvalid_o,    1'b0);
        check("er2_perr",   protocol_err_o, 1'b0);
        next_cycle();
        idle();

        // ---------------- Reset mid-operation ----------------
        m0_req_i = 1'b1; m0_addr_i = 32'h800; s_gnt_i = 1'b1;
        next_cycle();
        next_cycle();                              // cnt = 2, last = 0
        idle();
        settle();
        check("rm_busy_pre", busy_o, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rm_busy_async", busy_o, 1'b0);
        next_cycle();
        rst_n = 1'b1;
        m0_req_i = 1'b1; m0_addr_i = 32'h900;
        m1_req_i = 1'b1; m1_addr_i = 32'hA00;
        s_gnt_i  = 1'b1;
        settle();
        check("rm_s_req",  s_req_o,  1'b1);
        check("rm_m0_gnt", m0_gnt_o, 1'b1);
        check("rm_m1_gnt", m1_gnt_o, 1'b0);
        check("rm_addr",   s_addr_o, 32'h900);
        next_cycle();
        idle();
        s_rvalid_i = 1'b1; s_rdata_i = 32'h99;
        settle();
        check("rm_m0_rv", m0_rvalid_o,    1'b1);
        check("rm_perr",  protocol_err_o, 1'b0);
        next_cycle();
        idle();
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cv32e40p_instr_bus_arbiter.md
# cv32e40p_instr_bus_arbiter

Two-requester OBI arbiter for the core's single instruction-memory port. It shares the port between requester 0 (the IF-stage prefetch buffer) and requester 1 (a secondary instruction-side master, e.g. the debug program-buffer loader or a boot loader). Grants are issued one address phase per cycle, and up to MAX_OUTSTANDING transactions may be in flight. Each response is routed back to the requester that issued it, using an in-order tag FIFO.

## Interface
- MAX_OUTSTANDING, 2: maximum accepted-but-unanswered transactions (legal 1..8); sizes the tag FIFO.
- FIXED_PRIO, 0: 0 = round-robin between requesters; 1 = requester 0 always wins ties.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- m0_req_i  in  1  requester 0 address-phase request
- m0_addr_i  in  32  requester 0 address
- m0_gnt_o  out  1  requester 0 grant
- m0_rvalid_o  out  1  requester 0 response valid
- m0_rdata_o  out  32  requester 0 read data
- m0_err_o  out  1  requester 0 bus error (qualified by m0_rvalid_o)
- m1_req_i, m1_addr_i, m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o: same as requester 0, for requester 1
- s_req_o  out  1  request to memory
- s_addr_o  out  32  address to memory
- s_gnt_i  in  1  memory grant
- s_rvalid_i  in  1  memory response valid
- s_rdata_i  in  32  memory read data
- s_err_i  in  1  memory bus error
- busy_o  out  1  one or more transactions outstanding
- protocol_err_o  out  1  one-cycle pulse when s_rvalid_i arrives with no transaction outstanding

## Operation
**State**
- cnt: outstanding counter, width $clog2(MAX_OUTSTANDING+1).
- Tag FIFO: MAX_OUTSTANDING entries of 1 bit (requester id). Read and write pointers wrap modulo MAX_OUTSTANDING.
- last: 1-bit id of the last requester granted. Reset value is 1, so requester 0 wins the first tie.

**Arbitration (combinational)**
- Only one requesting: that requester is the winner.
- Both requesting: if FIXED_PRIO=1, winner = 0. Otherwise winner = ~last.
- full = (cnt == MAX_OUTSTANDING).
- s_req_o = (m0_req_i | m1_req_i) & ~full.
- s_addr_o = address of the winner. When no requester is active, s_addr_o = m0_addr_i.
- mX_gnt_o = s_gnt_i & s_req_o & (winner == X). The loser's gnt is 0.

**Handshake (hs = s_req_o & s_gnt_i)**
- Push the winner id into the FIFO.
- last <= winner.
- Requester stability (req/addr held until gnt) is the requester's obligation. The winner may change between cycles while no grant has been given. This is legal OBI.

**Response routing (combinational)**
- head = FIFO[rd_ptr].
- mX_rvalid_o = s_rvalid_i & (cnt != 0) & (head == X).
- s_rdata_i is broadcast to both mX_rdata_o. s_err_i is broadcast to both mX_err_o.
- A valid response pops the FIFO.

**Counter**
- cnt <= cnt + hs − pop.
- Handshake and pop in the same cycle: cnt is unchanged, and the push and pop both occur.
- full blocks new requests even when s_rvalid_i is high in the same cycle. This avoids a rvalid→req combinational path.

**Protocol error**
- s_rvalid_i while cnt == 0: the response is dropped (no mX_rvalid_o), protocol_err_o pulses, and state is unchanged.

**Status**
- busy_o = (cnt != 0).

## Timing
- Reset values:
  - cnt = 0, pointers = 0, last = 1.
  - All outputs that depend on state are 0: busy_o = 0, protocol_err_o = 0. With inputs low, mX_rvalid_o = 0, mX_gnt_o = 0 and s_req_o = 0.
- Zero-cycle latency on the request path (mX_req_i → s_req_o) and on the response path (s_rvalid_i → mX_rvalid_o). No registers sit in the data paths.
- cnt, FIFO and last update on the rising clk edge following the handshake or response cycle.
- Reset asserted mid-transaction discards all tags. Memory-side responses in flight are the memory's responsibility to flush. After reset, the arbiter reports them as protocol errors.
- MAX_OUTSTANDING=1: strict alternation of address phase and response. s_req_o is low from the handshake until the response cycle.

## Test plan
- **Single requester:** m0 requests 0x100, 0x104 with s_gnt_i=1 and responses 1 cycle later. Required: m0_gnt_o asserted on both; m0_rvalid_o with data 0xA, 0xB; m1 outputs stay 0; busy_o falls after the 2nd response.
- **Round-robin tie:** m0 and m1 both hold req with constant gnt. Required: grant order m0, m1, m0, m1. With FIXED_PRIO=1: m0 every cycle.
- **Interleaved routing:** grants go m1(0x200), m0(0x300), then two responses. Required: 1st response goes to m1_rvalid_o, 2nd to m0_rvalid_o, and rdata is passed through unchanged.
- **Full and same-cycle events:** with MAX_OUTSTANDING=2, two grants are made without responses. Required: s_req_o=0 while cnt=2, including in the cycle when the 1st response arrives. s_req_o reasserts the next cycle. A handshake coinciding with a response leaves cnt unchanged.
- **Unexpected response and error:** s_rvalid_i with cnt=0. Required: a protocol_err_o pulse, no mX_rvalid_o, cnt stays 0. Also, s_err_i=1 on a routed response appears on the owning mX_err_o in the same cycle.
- **Reset mid-operation:** rst_n low with cnt=2. Required: cnt=0, busy_o=0 and last=1 immediately (asynchronous). The next tie goes to m0.
